// File: rtl/led_pwm_fader.sv
// Per-channel LED brightness registers with optional linear fade and glitch-free 8-bit PWM.
// Define LED_PWM_GAMMA_EN to square brightness (upper byte) before the PWM compare.
module led_pwm_fader #(
  parameter int unsigned NUM_CH   = 6,
  parameter int unsigned FADE_DIV = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [2:0]        rd_addr,
  output logic [7:0]        rd_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              busy
);

  localparam int unsigned   PW       = $clog2(FADE_DIV);
  localparam logic [PW-1:0] PrescMax = PW'(FADE_DIV - 1);

  logic [7:0]        target_q  [NUM_CH];
  logic [7:0]        target_d  [NUM_CH];
  logic [7:0]        current_q [NUM_CH];
  logic [7:0]        current_d [NUM_CH];
  logic [7:0]        shadow_q  [NUM_CH];
  logic [7:0]        shadow_d  [NUM_CH];
  logic [7:0]        duty_src  [NUM_CH];
  logic [7:0]        mode_q, mode_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [NUM_CH-1:0] pwm_d;
  logic              fade_en;
  logic              tick;

  assign fade_en = mode_q[0];
  // Prescaler free-runs so enabling fade never restarts the step interval.
  assign tick    = (presc_q == PrescMax);

`ifdef LED_PWM_GAMMA_EN
  logic [15:0] gamma_sq [NUM_CH];

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      gamma_sq[i] = 16'(current_q[i]) * 16'(current_q[i]);
      duty_src[i] = gamma_sq[i][15:8];
    end
  end
`else
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      duty_src[i] = current_q[i];
    end
  end
`endif

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    cnt_d   = cnt_q + 8'd1;
    mode_d  = (wr_en && wr_addr == 3'd6) ? wr_data : mode_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      target_d[i] = target_q[i];
      if (wr_en && (wr_addr == 3'd7 || wr_addr == 3'(i))) begin
        target_d[i] = wr_data;
      end
      // Steps compare against the pre-write target; a same-edge write applies from the next tick.
      current_d[i] = current_q[i];
      if (!fade_en) begin
        current_d[i] = target_q[i];
      end else if (tick) begin
        if (current_q[i] < target_q[i]) begin
          current_d[i] = current_q[i] + 8'd1;
        end else if (current_q[i] > target_q[i]) begin
          current_d[i] = current_q[i] - 8'd1;
        end
      end
      shadow_d[i] = (cnt_q == 8'hff) ? duty_src[i] : shadow_q[i];
      pwm_d[i]    = (cnt_q < shadow_q[i]);
    end
  end

  always_comb begin
    rd_data = (rd_addr == 3'd6) ? mode_q : 8'h00;
    busy    = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rd_addr == 3'(i)) begin
        rd_data = current_q[i];
      end
      if (current_q[i] != target_q[i]) begin
        busy = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        target_q[i]  <= '0;
        current_q[i] <= '0;
        shadow_q[i]  <= '0;
      end
      mode_q  <= '0;
      cnt_q   <= '0;
      presc_q <= '0;
      pwm_out <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        target_q[i]  <= target_d[i];
        current_q[i] <= current_d[i];
        shadow_q[i]  <= shadow_d[i];
      end
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      pwm_out <= pwm_d;
    end
  end

endmodule
